// File: rtl/gcm_block_feeder_if.sv
// gcm_block_feeder_if
// Bundles the host write stream and the core-facing block channel of one
// gcm_block_feeder instance.
//   Host side : wr_valid/wr_ready handshake, wr_data (byte 0 = [127:120]),
//               wr_len (valid bytes 1..16), wr_last (final block of message).
//   Core side : req (level request from the core), data_out/len_out/total_out
//               (current block, its byte length, blocks in the message),
//               msg_valid, msg_done (last block on data_out), sticky err_len
//               and err_ovf.
// The feeder connects through the slave modport; the host/core model uses master.
interface gcm_block_feeder_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          wr_valid;
  logic          wr_ready;
  logic [127:0]  wr_data;
  logic [4:0]    wr_len;
  logic          wr_last;
  logic          req;
  logic [127:0]  data_out;
  logic [4:0]    len_out;
  logic [CW-1:0] total_out;
  logic          msg_valid;
  logic          msg_done;
  logic          err_len;
  logic          err_ovf;

  modport master (
    output wr_valid, wr_data, wr_len, wr_last, req,
    input  wr_ready, data_out, len_out, total_out, msg_valid, msg_done, err_len, err_ovf
  );

  modport slave (
    input  wr_valid, wr_data, wr_len, wr_last, req,
    output wr_ready, data_out, len_out, total_out, msg_valid, msg_done, err_len, err_ovf
  );
endinterface

// File: rtl/gcm_block_feeder.sv
// gcm_block_feeder
// Buffers one complete message of 128-bit blocks from a host valid/ready
// stream, then plays it to the AES-GCM core one block per cycle once the core
// raises its request. Bytes beyond a block's valid length are zeroed as the
// block is stored, so everything read back is already padded.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gcm_block_feeder_if.slave (host write stream + core block channel)
module gcm_block_feeder #(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  gcm_block_feeder_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Keep bytes 0..len-1 (byte 0 is the MSB byte), zero the rest.
  function automatic logic [127:0] pad_mask(input logic [127:0] d, input logic [4:0] len);
    logic [127:0] m;
    m = 128'd0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < len) m[127 - 8*i -: 8] = d[127 - 8*i -: 8];
      else             m[127 - 8*i -: 8] = 8'd0;
    end
    return m;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] wcnt_r, rptr_r, total_r;
  logic [127:0]  data_r;
  logic [4:0]    len_r;
  logic          msg_valid_r, err_len_r, err_ovf_r;

  logic [127:0]  buf_r  [DEPTH];
  logic [4:0]    lbuf_r [DEPTH];

  logic          len_bad_s;
  logic [4:0]    len_fix_s;
  logic [127:0]  wdata_s;
  logic          at_end_s, rptr_end_s;
  logic          accept_s, last_s, msg_done_s, wr_ready_s;
  logic [AW-1:0] widx_s, ridx_s;

  // An out-of-range length is stored as a full block and flagged.
  assign len_bad_s  = (bus.wr_len == 5'd0) || (bus.wr_len > 5'd16);
  assign len_fix_s  = len_bad_s ? 5'd16 : bus.wr_len;
  assign wdata_s    = pad_mask(bus.wr_data, len_fix_s);
  // The block landing in the final slot closes the message even without wr_last.
  assign at_end_s   = (wcnt_r == CW'(DEPTH - 1));
  assign rptr_end_s = (rptr_r == (total_r - CW'(1)));
  assign widx_s     = wcnt_r[AW-1:0];
  assign ridx_s     = rptr_r[AW-1:0] + AW'(1);

  // Next-state decode plus the combinational handshake and done pulse.
  always_comb begin
    state_nxt_s = state_r;
    wr_ready_s  = 1'b0;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    msg_done_s  = 1'b0;
    case (state_r)
      LOAD: begin
        // Gated by rst_n so the host sees wr_ready low while reset is held.
        wr_ready_s = rst_n;
        accept_s   = bus.wr_valid & rst_n;
        last_s     = accept_s & (bus.wr_last | at_end_s);
        if (last_s) state_nxt_s = READY;
        else        state_nxt_s = LOAD;
      end
      READY: begin
        if (bus.req) begin
          if (total_r == CW'(1)) begin
            msg_done_s  = 1'b1;
            state_nxt_s = LOAD;
          end else begin
            state_nxt_s = STREAM;
          end
        end else begin
          state_nxt_s = READY;
        end
      end
      STREAM: begin
        // req is deliberately ignored here: the stream never stalls.
        if (rptr_end_s) begin
          msg_done_s  = 1'b1;
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = STREAM;
        end
      end
      default: state_nxt_s = LOAD;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= LOAD;
    else        state_r <= state_nxt_s;
  end

  // Counters, registered outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_r      <= {CW{1'b0}};
      rptr_r      <= {CW{1'b0}};
      total_r     <= {CW{1'b0}};
      data_r      <= 128'd0;
      len_r       <= 5'd0;
      msg_valid_r <= 1'b0;
      err_len_r   <= 1'b0;
      err_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            wcnt_r <= wcnt_r + CW'(1);
            if (len_bad_s) err_len_r <= 1'b1;
            if (last_s) begin
              if (!bus.wr_last) err_ovf_r <= 1'b1;
              total_r     <= wcnt_r + CW'(1);
              msg_valid_r <= 1'b1;
              // For a 1-block message block 0 is still on the write port.
              if (wcnt_r == {CW{1'b0}}) begin
                data_r <= wdata_s;
                len_r  <= len_fix_s;
              end else begin
                data_r <= buf_r[0];
                len_r  <= lbuf_r[0];
              end
            end
          end
        end
        READY: begin
          if (bus.req) begin
            if (total_r == CW'(1)) begin
              msg_valid_r <= 1'b0;
              wcnt_r      <= {CW{1'b0}};
              rptr_r      <= {CW{1'b0}};
            end else begin
              rptr_r <= CW'(1);
              data_r <= buf_r[1];
              len_r  <= lbuf_r[1];
            end
          end
        end
        STREAM: begin
          if (rptr_end_s) begin
            // Outputs keep the last block through LOAD.
            msg_valid_r <= 1'b0;
            wcnt_r      <= {CW{1'b0}};
            rptr_r      <= {CW{1'b0}};
          end else begin
            rptr_r <= rptr_r + CW'(1);
            data_r <= buf_r[ridx_s];
            len_r  <= lbuf_r[ridx_s];
          end
        end
        default: begin
          msg_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Message buffer; contents survive reset, only the counters are cleared.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      buf_r[widx_s]  <= wdata_s;
      lbuf_r[widx_s] <= len_fix_s;
    end
  end

  assign bus.wr_ready  = wr_ready_s;
  assign bus.msg_done  = msg_done_s;
  assign bus.data_out  = data_r;
  assign bus.len_out   = len_r;
  assign bus.total_out = total_r;
  assign bus.msg_valid = msg_valid_r;
  assign bus.err_len   = err_len_r;
  assign bus.err_ovf   = err_ovf_r;
endmodule

// File: tb/tb_gcm_block_feeder.sv
// tb_gcm_block_feeder
// Directed bench for gcm_block_feeder (DEPTH=16). Inputs change on the falling
// edge; outputs are sampled on the falling edge or 1 time unit after an input
// change, well away from the rising edge.
module tb_gcm_block_feeder;
  logic clk;
  logic rst_n;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  gcm_block_feeder_if #(.DEPTH(16)) bus ();

  gcm_block_feeder #(.DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one block for exactly one rising edge (wr_ready is assumed high).
  task automatic write_block(input logic [127:0] d, input logic [4:0] l, input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_len   = l;
    bus.wr_last  = last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_data = 128'd0; bus.wr_len = 5'd0; bus.wr_last = 1'b0; bus.req = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if (bus.wr_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_wr_ready got %b exp 0", bus.wr_ready); end
    cmp_cnt++; if (bus.data_out !== 128'd0) begin err_cnt++; $display("FAIL rst_data got %h exp 0", bus.data_out); end
    cmp_cnt++; if (bus.len_out !== 5'd0) begin err_cnt++; $display("FAIL rst_len got %0d exp 0", bus.len_out); end
    cmp_cnt++; if (bus.total_out !== 5'd0) begin err_cnt++; $display("FAIL rst_total got %0d exp 0", bus.total_out); end
    cmp_cnt++; if ({bus.msg_valid, bus.msg_done, bus.err_len, bus.err_ovf} !== 4'b0000) begin err_cnt++;
      $display("FAIL rst_flags got %b exp 0000", {bus.msg_valid, bus.msg_done, bus.err_len, bus.err_ovf}); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if (bus.wr_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_rel_wr_ready got %b exp 1", bus.wr_ready); end
    cmp_cnt++; if (bus.msg_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rel_msg_valid got %b exp 0", bus.msg_valid); end
  endtask

  task automatic test_ptext4();
    logic [127:0] src [4];
    logic [127:0] exp_d [4];
    logic [4:0]   exp_l [4];
    logic         exp_done;
    src[0] = 128'hd9313225f88406e5a55909c5aff5269a;
    src[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
    src[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
    src[3] = 128'hb16aedf5aa0de657ba637b39ffffffff;
    exp_d[0] = src[0]; exp_d[1] = src[1]; exp_d[2] = src[2];
    exp_d[3] = 128'hb16aedf5aa0de657ba637b3900000000;
    exp_l[0] = 5'd16; exp_l[1] = 5'd16; exp_l[2] = 5'd16; exp_l[3] = 5'd12;
    for (int i = 0; i < 4; i++) write_block(src[i], exp_l[i], (i == 3));
    bus.wr_valid = 1'b0;
    #1;
    cmp_cnt++; if (bus.msg_valid !== 1'b1) begin err_cnt++; $display("FAIL pt_msg_valid got %b exp 1", bus.msg_valid); end
    cmp_cnt++; if (bus.total_out !== 5'd4) begin err_cnt++; $display("FAIL pt_total got %0d exp 4", bus.total_out); end
    cmp_cnt++; if (bus.data_out !== exp_d[0]) begin err_cnt++; $display("FAIL pt_blk0 got %h exp %h", bus.data_out, exp_d[0]); end
    cmp_cnt++; if (bus.wr_ready !== 1'b0) begin err_cnt++; $display("FAIL pt_wr_ready_ready got %b exp 0", bus.wr_ready); end
    // One idle READY cycle without req: block 0 must simply be held.
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if (bus.data_out !== exp_d[0]) begin err_cnt++; $display("FAIL pt_hold0 got %h exp %h", bus.data_out, exp_d[0]); end
    bus.req = 1'b1;
    #1;
    cmp_cnt++; if (bus.msg_done !== 1'b0) begin err_cnt++; $display("FAIL pt_done_R got %b exp 0", bus.msg_done); end
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      exp_done = (k == 3);
      cmp_cnt++; if (bus.data_out !== exp_d[k]) begin err_cnt++; $display("FAIL pt_blk%0d got %h exp %h", k, bus.data_out, exp_d[k]); end
      cmp_cnt++; if (bus.len_out !== exp_l[k]) begin err_cnt++; $display("FAIL pt_len%0d got %0d exp %0d", k, bus.len_out, exp_l[k]); end
      cmp_cnt++; if (bus.msg_done !== exp_done) begin err_cnt++; $display("FAIL pt_done%0d got %b exp %b", k, bus.msg_done, exp_done); end
    end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    #1;
    cmp_cnt++; if (bus.msg_valid !== 1'b0) begin err_cnt++; $display("FAIL pt_end_valid got %b exp 0", bus.msg_valid); end
    cmp_cnt++; if (bus.wr_ready !== 1'b1) begin err_cnt++; $display("FAIL pt_end_wr_ready got %b exp 1", bus.wr_ready); end
    cmp_cnt++; if (bus.data_out !== exp_d[3]) begin err_cnt++; $display("FAIL pt_end_hold got %h exp %h", bus.data_out, exp_d[3]); end
    cmp_cnt++; if (bus.err_len !== 1'b0) begin err_cnt++; $display("FAIL pt_err_len got %b exp 0", bus.err_len); end
  endtask

  task automatic test_iv5();
    logic [127:0] src [5];
    logic         exp_done;
    src[0] = 128'h9313225df88406e5a55909c5aff569aa;
    src[1] = 128'h6a7a9538534f7da1e4c303d2a318a728;
    src[2] = 128'hc3c0c95156809539fcf0e2429a6b5254;
    src[3] = 128'h16aedf5ba637b3900000000000000000;
    src[4] = 128'h000000000000000000000000000001e0;
    for (int i = 0; i < 5; i++) write_block(src[i], 5'd16, (i == 4));
    bus.wr_valid = 1'b0;
    bus.req = 1'b1;
    #1;
    cmp_cnt++; if (bus.total_out !== 5'd5) begin err_cnt++; $display("FAIL iv_total got %0d exp 5", bus.total_out); end
    cmp_cnt++; if (bus.data_out !== src[0]) begin err_cnt++; $display("FAIL iv_blk0 got %h exp %h", bus.data_out, src[0]); end
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      exp_done = (k == 4);
      cmp_cnt++; if (bus.data_out !== src[k]) begin err_cnt++; $display("FAIL iv_blk%0d got %h exp %h", k, bus.data_out, src[k]); end
      cmp_cnt++; if (bus.msg_done !== exp_done) begin err_cnt++; $display("FAIL iv_done%0d got %b exp %b", k, bus.msg_done, exp_done); end
      cmp_cnt++; if (bus.wr_ready !== 1'b0) begin err_cnt++; $display("FAIL iv_wr_ready%0d got %b exp 0", k, bus.wr_ready); end
    end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    #1;
    cmp_cnt++; if (bus.wr_ready !== 1'b1) begin err_cnt++; $display("FAIL iv_wr_ready_R5 got %b exp 1", bus.wr_ready); end
    cmp_cnt++; if (bus.msg_valid !== 1'b0) begin err_cnt++; $display("FAIL iv_valid_R5 got %b exp 0", bus.msg_valid); end
  endtask

  task automatic test_aad1();
    // req is already high while the message loads.
    bus.req = 1'b1;
    write_block(128'hfeedfacedeadbeeffeedfacedeadbeef, 5'd16, 1'b1);
    bus.wr_valid = 1'b0;
    #1;
    cmp_cnt++; if (bus.data_out !== 128'hfeedfacedeadbeeffeedfacedeadbeef) begin err_cnt++; $display("FAIL aad_blk0 got %h exp feedface..", bus.data_out); end
    cmp_cnt++; if (bus.total_out !== 5'd1) begin err_cnt++; $display("FAIL aad_total got %0d exp 1", bus.total_out); end
    cmp_cnt++; if (bus.msg_done !== 1'b1) begin err_cnt++; $display("FAIL aad_done got %b exp 1", bus.msg_done); end
    cmp_cnt++; if (bus.msg_valid !== 1'b1) begin err_cnt++; $display("FAIL aad_valid got %b exp 1", bus.msg_valid); end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    #1;
    cmp_cnt++; if ({bus.msg_valid, bus.msg_done, bus.wr_ready} !== 3'b001) begin err_cnt++;
      $display("FAIL aad_back_load got %b exp 001", {bus.msg_valid, bus.msg_done, bus.wr_ready}); end
    // Second message: one block of 5 valid bytes, must come out padded.
    write_block(128'h0123456789abcdef0123456789abcdef, 5'd5, 1'b1);
    bus.wr_valid = 1'b0;
    #1;
    cmp_cnt++; if (bus.data_out !== 128'h01234567890000000000000000000000) begin err_cnt++; $display("FAIL aad2_pad got %h exp 0123456789 then zeros", bus.data_out); end
    cmp_cnt++; if (bus.len_out !== 5'd5) begin err_cnt++; $display("FAIL aad2_len got %0d exp 5", bus.len_out); end
    cmp_cnt++; if (bus.msg_done !== 1'b0) begin err_cnt++; $display("FAIL aad2_done_noreq got %b exp 0", bus.msg_done); end
    bus.req = 1'b1;
    #1;
    cmp_cnt++; if (bus.msg_done !== 1'b1) begin err_cnt++; $display("FAIL aad2_done got %b exp 1", bus.msg_done); end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    #1;
    cmp_cnt++; if (bus.msg_valid !== 1'b0) begin err_cnt++; $display("FAIL aad2_end_valid got %b exp 0", bus.msg_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0]   b8;
    logic [127:0] exp_b;
    logic         exp_done;
    for (int i = 0; i < 16; i++) begin
      b8 = 8'(i + 1);
      write_block({16{b8}}, (i == 3) ? 5'd0 : 5'd16, 1'b0);
    end
    // 17th block offered while the feeder is busy with the truncated message.
    bus.wr_valid = 1'b1; bus.wr_data = {16{8'h11}}; bus.wr_len = 5'd16; bus.wr_last = 1'b0;
    #1;
    cmp_cnt++; if (bus.total_out !== 5'd16) begin err_cnt++; $display("FAIL ovf_total got %0d exp 16", bus.total_out); end
    cmp_cnt++; if (bus.err_ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_err_ovf got %b exp 1", bus.err_ovf); end
    cmp_cnt++; if (bus.err_len !== 1'b1) begin err_cnt++; $display("FAIL ovf_err_len got %b exp 1", bus.err_len); end
    cmp_cnt++; if (bus.wr_ready !== 1'b0) begin err_cnt++; $display("FAIL ovf_wr_ready got %b exp 0", bus.wr_ready); end
    bus.req = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); @(negedge clk);
      b8 = 8'(k + 1);
      exp_b = {16{b8}};
      exp_done = (k == 15);
      cmp_cnt++; if (bus.data_out !== exp_b) begin err_cnt++; $display("FAIL ovf_blk%0d got %h exp %h", k, bus.data_out, exp_b); end
      cmp_cnt++; if (bus.len_out !== 5'd16) begin err_cnt++; $display("FAIL ovf_len%0d got %0d exp 16", k, bus.len_out); end
      cmp_cnt++; if (bus.msg_done !== exp_done) begin err_cnt++; $display("FAIL ovf_done%0d got %b exp %b", k, bus.msg_done, exp_done); end
    end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    #1;
    cmp_cnt++; if (bus.wr_ready !== 1'b1) begin err_cnt++; $display("FAIL ovf_reload_ready got %b exp 1", bus.wr_ready); end
    @(posedge clk); @(negedge clk);
    write_block({16{8'h12}}, 5'd16, 1'b1);
    bus.wr_valid = 1'b0;
    #1;
    cmp_cnt++; if (bus.data_out !== {16{8'h11}}) begin err_cnt++; $display("FAIL ovf_next_blk0 got %h exp 1111..", bus.data_out); end
    cmp_cnt++; if (bus.total_out !== 5'd2) begin err_cnt++; $display("FAIL ovf_next_total got %0d exp 2", bus.total_out); end
    bus.req = 1'b1;
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if (bus.data_out !== {16{8'h12}}) begin err_cnt++; $display("FAIL ovf_next_blk1 got %h exp 1212..", bus.data_out); end
    cmp_cnt++; if (bus.msg_done !== 1'b1) begin err_cnt++; $display("FAIL ovf_next_done got %b exp 1", bus.msg_done); end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    #1;
    cmp_cnt++; if (bus.err_ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky got %b exp 1", bus.err_ovf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) write_block({16{8'(8'h40 + i)}}, 5'd16, (i == 3));
    bus.wr_valid = 1'b0;
    bus.req = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if (bus.data_out !== {16{8'h42}}) begin err_cnt++; $display("FAIL ar_blk2 got %h exp 4242..", bus.data_out); end
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++; if (bus.data_out !== 128'd0) begin err_cnt++; $display("FAIL ar_data got %h exp 0", bus.data_out); end
    cmp_cnt++; if (bus.total_out !== 5'd0) begin err_cnt++; $display("FAIL ar_total got %0d exp 0", bus.total_out); end
    cmp_cnt++; if (bus.len_out !== 5'd0) begin err_cnt++; $display("FAIL ar_len got %0d exp 0", bus.len_out); end
    cmp_cnt++; if ({bus.wr_ready, bus.msg_valid, bus.msg_done, bus.err_len, bus.err_ovf} !== 5'b00000) begin err_cnt++;
      $display("FAIL ar_flags got %b exp 00000", {bus.wr_ready, bus.msg_valid, bus.msg_done, bus.err_len, bus.err_ovf}); end
    bus.req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp_cnt++; if (bus.wr_ready !== 1'b1) begin err_cnt++; $display("FAIL ar_rel_ready got %b exp 1", bus.wr_ready); end
    @(negedge clk);
    write_block(128'h00112233445566778899aabbccddeeff, 5'd16, 1'b0);
    write_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 5'd8, 1'b1);
    bus.wr_valid = 1'b0;
    bus.req = 1'b1;
    #1;
    cmp_cnt++; if (bus.total_out !== 5'd2) begin err_cnt++; $display("FAIL ar2_total got %0d exp 2", bus.total_out); end
    cmp_cnt++; if (bus.data_out !== 128'h00112233445566778899aabbccddeeff) begin err_cnt++; $display("FAIL ar2_blk0 got %h exp 0011..", bus.data_out); end
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if (bus.data_out !== 128'h0f1e2d3c4b5a69780000000000000000) begin err_cnt++; $display("FAIL ar2_blk1 got %h exp 0f1e2d3c4b5a6978 then zeros", bus.data_out); end
    cmp_cnt++; if (bus.len_out !== 5'd8) begin err_cnt++; $display("FAIL ar2_len1 got %0d exp 8", bus.len_out); end
    cmp_cnt++; if (bus.msg_done !== 1'b1) begin err_cnt++; $display("FAIL ar2_done got %b exp 1", bus.msg_done); end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    #1;
    cmp_cnt++; if (bus.wr_ready !== 1'b1) begin err_cnt++; $display("FAIL ar2_end_ready got %b exp 1", bus.wr_ready); end
  endtask

  task automatic test_req_drop();
    write_block({16{8'ha1}}, 5'd16, 1'b0);
    write_block({16{8'hb2}}, 5'd16, 1'b0);
    write_block({16{8'hc3}}, 5'd16, 1'b1);
    bus.wr_valid = 1'b0;
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (bus.data_out !== {16{8'hb2}}) begin err_cnt++; $display("FAIL rd_blk1 got %h exp b2b2..", bus.data_out); end
    cmp_cnt++; if (bus.msg_done !== 1'b0) begin err_cnt++; $display("FAIL rd_done1 got %b exp 0", bus.msg_done); end
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if (bus.data_out !== {16{8'hc3}}) begin err_cnt++; $display("FAIL rd_blk2 got %h exp c3c3..", bus.data_out); end
    cmp_cnt++; if (bus.msg_done !== 1'b1) begin err_cnt++; $display("FAIL rd_done2 got %b exp 1", bus.msg_done); end
    @(posedge clk); @(negedge clk);
    cmp_cnt++; if ({bus.msg_valid, bus.wr_ready} !== 2'b01) begin err_cnt++; $display("FAIL rd_end got %b exp 01", {bus.msg_valid, bus.wr_ready}); end
  endtask

  initial begin
    test_reset();
    test_ptext4();
    test_iv5();
    test_aad1();
    test_overflow();
    test_async_reset();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end
endmodule
